// File: rtl/parking_pkg.sv
// parking_pkg
// Shared definitions for the parking exit gate:
//   - gate FSM state codes (IDLE, WAIT_PAY, BAD_PAY, OPEN, BLOCK)
//   - active-low seven-segment glyphs shown on HEX_1/HEX_2
//   - the accepted payment token and a helper that recognises it
package parking_pkg;

    typedef logic [2:0] gate_state_t;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_PAY = 3'd1;
    localparam logic [2:0] ST_BAD_PAY  = 3'd2;
    localparam logic [2:0] ST_OPEN     = 3'd3;
    localparam logic [2:0] ST_BLOCK    = 3'd4;

    // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_P   = 7'b0001100;
    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_5   = 7'b0010010;

    localparam logic [1:0] VALID_CODE_1 = 2'b10;
    localparam logic [1:0] VALID_CODE_2 = 2'b01;

    function automatic logic code_is_valid(input logic [1:0] code_1,
                                           input logic [1:0] code_2);
        return (code_1 == VALID_CODE_1) && (code_2 == VALID_CODE_2);
    endfunction

endpackage

// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter
// Counts cars currently in the lot. Saturates at CAPACITY on entry and at 0
// on exit; an entry and an exit in the same cycle cancel out.
// Ports:
//   clk, reset  : clock, synchronous active-high reset (clears the count)
//   inc         : one car entered this cycle
//   dec         : one car left this cycle
//   occupancy   : registered car count
//   lot_full    : high while occupancy equals CAPACITY
module parking_occupancy_counter
    import parking_pkg::*;
#(
    parameter int CAPACITY = 8,
    parameter int OCC_W    = $clog2(CAPACITY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [OCC_W-1:0] occupancy,
    output logic             lot_full
);

    localparam logic [OCC_W-1:0] FULL = OCC_W'(CAPACITY);

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy <= '0;
        end else if (inc && !dec) begin
            if (occupancy != FULL) begin
                occupancy <= occupancy + 1'b1;
            end
        end else if (dec && !inc) begin
            if (occupancy != '0) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    assign lot_full = (occupancy == FULL);

endmodule

// File: rtl/parking_exit_gate.sv
// parking_exit_gate
// Exit barrier controller: waits for a payment token, opens the barrier on a
// valid code, detects tailgating and keeps the lot occupancy count.
// Optional feature: define EXIT_TIMEOUT_EN to make BAD_PAY give up and
// return to IDLE after TIMEOUT cycles without a valid code.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   sensor_exit              : car present at the exit gate
//   sensor_clear             : car seen past the barrier
//   pay_code_1, pay_code_2   : payment token digits
//   car_entered              : one-cycle pulse per car admitted at the entrance
//   GREEN_LED, RED_LED       : gate lamps (registered)
//   HEX_1, HEX_2             : active-low seven-segment digits (registered)
//   occupancy, lot_full      : current car count and full flag
module parking_exit_gate
    import parking_pkg::*;
#(
    parameter int CAPACITY    = 8,
    parameter int WAIT_CYCLES = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             sensor_exit,
    input  logic                             sensor_clear,
    input  logic [1:0]                       pay_code_1,
    input  logic [1:0]                       pay_code_2,
    input  logic                             car_entered,
    output logic                             GREEN_LED,
    output logic                             RED_LED,
    output logic [6:0]                       HEX_1,
    output logic [6:0]                       HEX_2,
    output logic [$clog2(CAPACITY + 1)-1:0]  occupancy,
    output logic                             lot_full
);

    localparam int WAIT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

    gate_state_t       state;
    gate_state_t       next_state;
    gate_state_t       shown_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              code_ok;
    logic              car_left;
    logic              entering;

    assign code_ok  = code_is_valid(pay_code_1, pay_code_2);
    // Any clear while open counts one departure, tailgate or not.
    assign car_left = (state == ST_OPEN) && sensor_clear;

`ifdef EXIT_TIMEOUT_EN
    localparam int TIMEOUT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    logic [TIMEOUT_W-1:0] timeout_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_cnt <= '0;
        end else begin
            timeout_cnt <= (state == ST_BAD_PAY) ? timeout_cnt + 1'b1 : '0;
        end
    end
`else
    // Keeps the parameter referenced when the timeout is compiled out.
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (sensor_exit) begin
                    next_state = ST_WAIT_PAY;
                end
            end
            ST_WAIT_PAY: begin
                // The code is only judged once the entry window has elapsed.
                if (wait_cnt == WAIT_LAST) begin
                    next_state = code_ok ? ST_OPEN : ST_BAD_PAY;
                end
            end
            ST_BAD_PAY: begin
                if (code_ok) begin
                    next_state = ST_OPEN;
                end
`ifdef EXIT_TIMEOUT_EN
                else if (timeout_cnt == TIMEOUT_LAST) begin
                    next_state = ST_IDLE;
                end
`endif
            end
            ST_OPEN: begin
                if (sensor_clear) begin
                    next_state = sensor_exit ? ST_BLOCK : ST_IDLE;
                end
            end
            ST_BLOCK: begin
                if (code_ok) begin
                    next_state = ST_OPEN;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= (state == ST_WAIT_PAY) ? wait_cnt + 1'b1 : '0;
        end
    end

    // Outputs trail the state register by one cycle. shown_state remembers
    // which state the lamps currently show, so a change of state restarts
    // any blinking lamp at 1.
    assign entering = (state != shown_state);

    always_ff @(posedge clk) begin
        if (reset) begin
            shown_state <= ST_IDLE;
            GREEN_LED   <= 1'b0;
            RED_LED     <= 1'b0;
            HEX_1       <= SEG_OFF;
            HEX_2       <= SEG_OFF;
        end else begin
            shown_state <= state;
            case (state)
                ST_WAIT_PAY: begin
                    GREEN_LED <= 1'b0;
                    RED_LED   <= 1'b1;
                    HEX_1     <= SEG_P;
                    HEX_2     <= SEG_A;
                end
                ST_BAD_PAY: begin
                    GREEN_LED <= 1'b0;
                    RED_LED   <= entering ? 1'b1 : ~RED_LED;
                    HEX_1     <= SEG_E;
                    HEX_2     <= SEG_E;
                end
                ST_OPEN: begin
                    GREEN_LED <= entering ? 1'b1 : ~GREEN_LED;
                    RED_LED   <= 1'b0;
                    HEX_1     <= SEG_6;
                    HEX_2     <= SEG_0;
                end
                ST_BLOCK: begin
                    GREEN_LED <= 1'b0;
                    RED_LED   <= entering ? 1'b1 : ~RED_LED;
                    HEX_1     <= SEG_5;
                    HEX_2     <= SEG_P;
                end
                default: begin
                    GREEN_LED <= 1'b0;
                    RED_LED   <= 1'b0;
                    HEX_1     <= SEG_OFF;
                    HEX_2     <= SEG_OFF;
                end
            endcase
        end
    end

    parking_occupancy_counter #(
        .CAPACITY (CAPACITY),
        .OCC_W    ($clog2(CAPACITY + 1))
    ) u_occupancy (
        .clk       (clk),
        .reset     (reset),
        .inc       (car_entered),
        .dec       (car_left),
        .occupancy (occupancy),
        .lot_full  (lot_full)
    );

endmodule

// File: doc/parking_exit_gate.md
PARKING_EXIT_GATE -- requirements
Module: parking_exit_gate

Interface
REQ-001 Parameter CAPACITY, default 8: maximum number of cars in the lot.
REQ-002 Parameter WAIT_CYCLES, default 4: payment-entry window, in cycles, before codes are judged.
REQ-003 Parameter TIMEOUT, default 16: BAD_PAY abandon limit in cycles; used only when EXIT_TIMEOUT_EN is defined.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 sensor_exit  in  1  car present at exit gate.
REQ-007 sensor_clear  in  1  car has passed the barrier, seen on the far side.
REQ-008 pay_code_1, pay_code_2  in  2 each  payment token digits.
REQ-009 car_entered  in  1  one-cycle pulse from the entrance gate per admitted car.
REQ-010 GREEN_LED, RED_LED  out  1 each  gate lamps.
REQ-011 HEX_1, HEX_2  out  7 each  active-low seven-segment digits.
REQ-012 occupancy  out  $clog2(CAPACITY+1)  current car count.
REQ-013 lot_full  out  1  high when occupancy == CAPACITY.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT_PAY, BAD_PAY, OPEN and BLOCK, held in a registered state variable.
REQ-015 IDLE SHALL go to WAIT_PAY when sensor_exit=1, and otherwise stay in IDLE.
REQ-016 The wait counter SHALL increment each cycle in WAIT_PAY and clear in every other state.
REQ-017 WAIT_PAY SHALL stay put while the wait counter < WAIT_CYCLES, so the state lasts WAIT_CYCLES+1 cycles.
REQ-018 In the WAIT_PAY cycle where the wait counter == WAIT_CYCLES, the FSM SHALL go to OPEN if the code is valid and to BAD_PAY otherwise.
REQ-019 A code SHALL be valid only when pay_code_1==2'b10 and pay_code_2==2'b01.
REQ-020 BAD_PAY SHALL go to OPEN on a valid code and otherwise stay in BAD_PAY, subject to REQ-032.
REQ-021 OPEN with sensor_clear=1 and sensor_exit=0 SHALL go to IDLE and decrement occupancy.
REQ-022 OPEN with sensor_clear=1 and sensor_exit=1 (tailgate) SHALL go to BLOCK and decrement occupancy once.
REQ-023 OPEN SHALL stay in OPEN otherwise.
REQ-024 BLOCK SHALL go to OPEN on a valid code and otherwise stay in BLOCK.
REQ-025 Occupancy SHALL increment on car_entered and saturate at CAPACITY; a decrement SHALL saturate at 0.
REQ-026 When an increment and a decrement occur in the same cycle, occupancy SHALL be unchanged.
REQ-027 Outputs SHALL be registered and reflect the state one cycle after the state register updates:
  - IDLE: both LEDs 0; HEX_1/HEX_2 = 7'b1111111 (off).
  - WAIT_PAY: RED steady 1; HEX_1/HEX_2 = "P" 7'b0001100 / "A" 7'b0001000.
  - BAD_PAY: RED toggles every cycle; HEX_1/HEX_2 = "E"/"E" 7'b0000110.
  - OPEN: GREEN toggles every cycle, RED 0; HEX_1/HEX_2 = "6" 7'b0000010 / "0" 7'b1000000.
  - BLOCK: RED toggles every cycle, GREEN 0; HEX_1/HEX_2 = "5" 7'b0010010 / "P" 7'b0001100.
REQ-028 Every toggling LED SHALL start at 1 on the first output cycle of its state, and any non-toggling LED SHALL be driven to its steady value.
REQ-029 An unreachable state encoding SHALL go to IDLE on the next cycle.

Reset
REQ-030 While reset=1 at a clock edge, the block SHALL set state=IDLE, wait counter=0, occupancy=0, lot_full=0, both LEDs=0 and HEX_1/HEX_2=7'b1111111.
REQ-031 A reset asserted mid-transaction (any state) SHALL abandon the transaction and SHALL not alter occupancy other than clearing it to 0.

Configuration
REQ-032 With EXIT_TIMEOUT_EN defined, a timeout counter SHALL run in BAD_PAY, and after TIMEOUT cycles without a valid code the FSM SHALL go to IDLE; without the macro, BAD_PAY SHALL wait indefinitely and no timeout counter SHALL exist.

Structure
REQ-033 Package parking_pkg SHALL hold the state enum, the seven-segment glyph constants and the valid-code constants.
REQ-034 The occupancy counter with its saturation rules and lot_full SHALL be a sub-module, parking_occupancy_counter.

Verification
REQ-035 The bench SHALL cover a valid exit: sensor_exit pulse, code 10/01 held -> WAIT_PAY for 5 cycles, then OPEN; on sensor_clear, IDLE with occupancy 3->2.
REQ-036 The bench SHALL cover a wrong code: code 01/10 -> BAD_PAY with RED toggling and HEX "EE"; code later set to 10/01 -> OPEN next cycle.
REQ-037 The bench SHALL cover a tailgate: in OPEN, sensor_clear=1 and sensor_exit=1 -> BLOCK with HEX "5P" and occupancy decremented by 1 only.
REQ-038 The bench SHALL cover saturation: 9 car_entered pulses with CAPACITY=8 -> occupancy 8, lot_full=1; a decrement at 0 -> stays 0.
REQ-039 The bench SHALL cover a simultaneous event: car_entered in the same cycle as the OPEN->IDLE decrement -> occupancy unchanged.
REQ-040 The bench SHALL cover the timeout with EXIT_TIMEOUT_EN: BAD_PAY held 16 cycles -> IDLE; and a reset asserted in OPEN -> IDLE, occupancy 0, HEX off next cycle.
